// File: rtl/aes_pkg.sv
// Shared AES types and the ShiftRows/InvShiftRows byte permutations.
// Both directions come from one index formula so they cannot drift apart.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  row_t;
    typedef logic [127:0] state_t;

    localparam int unsigned NB = 4;

    // Row r, column c lives at s[32c+8r +: 8]; forward reads column (c+r), inverse (c-r).
    function automatic state_t permute_rows(input state_t s, input logic inverse);
        state_t      o;
        byte_t       b;
        int unsigned src;
        o = '0;
        for (int unsigned c = 0; c < NB; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                src = inverse ? ((c + NB - r) % NB) : ((c + r) % NB);
                b = s[32*src + 8*r +: 8];
                o[32*c + 8*r +: 8] = b;
            end
        end
        return o;
    endfunction

    function automatic state_t shift_rows(input state_t s);
        return permute_rows(s, 1'b0);
    endfunction

    function automatic state_t inv_shift_rows(input state_t s);
        return permute_rows(s, 1'b1);
    endfunction

endpackage

// File: rtl/stage_fifo.sv
// Circular elastic buffer with valid/ready on both sides, shared by the
// inverse-cipher handshake stages. in_ready depends only on registered count.
module stage_fifo #(
    parameter int unsigned WIDTH = 128,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       en,
    input  logic [WIDTH-1:0]           data,
    output logic                       in_ready,
    output logic                       done,
    output logic [WIDTH-1:0]           data_out,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic             push;
    logic             pop;

    // Explicit wrap keeps non-power-of-two and DEPTH=1 pointers in range.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign in_ready = (cnt < CW'(DEPTH));
    assign done     = (cnt != '0);
    assign push     = en && in_ready;
    assign pop      = done && out_ready;
    assign data_out = mem[rp];
    assign count    = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                mem[wp] <= data;
                wp      <= next_ptr(wp);
            end
            if (pop) begin
                rp <= next_ptr(rp);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/inv_shift_rows.sv
// InvShiftRows applied on the input side, result buffered in a stage_fifo
// so a stalled InvSubBytes stage never loses a state.
module inv_shift_rows
    import aes_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [127:0]               state,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [127:0]               state_out,
    output logic                       done,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    state_t shifted;

    assign shifted = aes_pkg::inv_shift_rows(state);

    stage_fifo #(
        .WIDTH (128),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .en        (en),
        .data      (shifted),
        .in_ready  (in_ready),
        .done      (done),
        .data_out  (state_out),
        .out_ready (out_ready),
        .count     (count)
    );

endmodule

// File: tb/tb_inv_shift_rows.sv
// Self-checking bench for inv_shift_rows: vector table, scoreboard-checked
// round trip, and directed backpressure / flush / reset sequences.
module tb_inv_shift_rows;
    import aes_pkg::*;

    logic         clk;
    logic         rst;
    logic         en;
    logic [127:0] state;
    logic         in_ready;
    logic         flush;
    logic [127:0] state_out;
    logic         done;
    logic         out_ready;
    logic [1:0]   count;

    int unsigned checks;
    int unsigned passed;
    int unsigned pops;
    logic [127:0] exp_q[$];

    typedef struct {
        logic [127:0] in_bytes;
        logic [127:0] exp_bytes;
    } vec_t;
    vec_t vecs[3];

    inv_shift_rows #(.DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .state     (state),
        .in_ready  (in_ready),
        .flush     (flush),
        .state_out (state_out),
        .done      (done),
        .out_ready (out_ready),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hex literal written as a FIPS byte string -> byte k at [8k +: 8].
    function automatic logic [127:0] from_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = s[127-8*k -: 8];
        return o;
    endfunction

    // Independent reference: output byte k (row k%4, col k/4) takes input byte at col (c+3r)%4.
    function automatic logic [127:0] ref_inv(input logic [127:0] s);
        logic [127:0] o;
        int r, c;
        for (int k = 0; k < 16; k++) begin
            r = k % 4;
            c = k / 4;
            o[8*k +: 8] = s[8*(4*((c + 3*r) % 4) + r) +: 8];
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Predicts each edge from the stable mid-cycle inputs.
    always @(negedge clk) begin
        if (!rst) begin
            if (flush) begin
                exp_q.delete();
            end else begin
                if (done && out_ready) begin
                    pops++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL spurious_pop: got %h expected no output", state_out);
                    end else begin
                        chk("scoreboard", state_out, exp_q.pop_front());
                    end
                end
                if (en && in_ready) exp_q.push_back(ref_inv(state));
            end
        end
    end

    task automatic send(input logic [127:0] s);
        en    = 1'b1;
        state = s;
        for (int t = 0; ; t++) begin
            if (in_ready) begin
                @(posedge clk); #1;
                break;
            end
            if (t > 200) begin
                checks++;
                $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
                break;
            end
            @(posedge clk); #1;
        end
        en = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        chk("drain_queue_empty", 128'(exp_q.size()), 128'd0);
        chk("drain_count", 128'(count), 128'd0);
    endtask

    logic stop_rand;
    int unsigned pops_before;

    initial begin
        checks = 0; passed = 0; pops = 0;
        rst = 1'b1; en = 1'b0; state = '0; flush = 1'b0; out_ready = 1'b0;
        stop_rand = 1'b0;

        vecs[0] = '{from_bytes(128'h7ad5fda789ef4e272bca100b3d9ff59f),
                    from_bytes(128'h7a9f102789d5f50b2beffd9f3dca4ea7)};
        vecs[1] = '{from_bytes(128'h000102030405060708090a0b0c0d0e0f),
                    from_bytes(128'h000d0a0704010e0b0805020f0c090603)};
        vecs[2] = '{128'h0, 128'h0};

        #12;
        chk("reset_count", 128'(count), 128'd0);
        chk("reset_done", 128'(done), 128'd0);
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        chk("reset_state_out", state_out, 128'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Latency from empty: valid right after the accepting edge.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            en = 1'b1; state = vecs[i].in_bytes;
            @(posedge clk); #1;
            en = 1'b0;
            chk("vec_done", 128'(done), 128'd1);
            chk("vec_state_out", state_out, vecs[i].exp_bytes);
            @(posedge clk); #1;
            chk("vec_popped", 128'(done), 128'd0);
        end

        // Round trip through the forward permutation, random backpressure.
        pops_before = pops;
        fork
            begin
                logic [127:0] orig;
                for (int i = 0; i < 1000; i++) begin
                    orig = {$urandom, $urandom, $urandom, $urandom};
                    send(aes_pkg::shift_rows(orig));
                end
                stop_rand = 1'b1;
            end
            begin
                while (!stop_rand) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        chk("roundtrip_pop_count", 128'(pops - pops_before), 128'd1000);

        // Backpressure: A, B fill the queue, C waits at the source.
        out_ready = 1'b0;
        pops_before = pops;
        send(128'hA);
        send(128'hB);
        chk("bp_in_ready", 128'(in_ready), 128'd0);
        chk("bp_count", 128'(count), 128'd2);
        en = 1'b1; state = 128'hC;
        repeat (3) begin @(posedge clk); #1; end
        chk("bp_held_count", 128'(count), 128'd2);
        chk("bp_head_is_a", state_out, ref_inv(128'hA));
        out_ready = 1'b1;
        send(128'hC);
        drain();
        chk("bp_pop_count", 128'(pops - pops_before), 128'd3);

        // Simultaneous push/pop at count 1 over 10 cycles.
        out_ready = 1'b0;
        send(128'h1234);
        out_ready = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            state = {4{$urandom}};
            @(posedge clk); #1;
            chk("pp_count", 128'(count), 128'd1);
            chk("pp_done", 128'(done), 128'd1);
        end
        en = 1'b0;
        drain();

        // Flush at count 2 with a concurrent offer.
        out_ready = 1'b0;
        send(128'h11);
        send(128'h22);
        flush = 1'b1; en = 1'b1; state = 128'h33;
        @(posedge clk); #1;
        flush = 1'b0; en = 1'b0;
        chk("flush_count", 128'(count), 128'd0);
        chk("flush_done", 128'(done), 128'd0);
        chk("flush_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk); #1;
        chk("flush_not_stored", 128'(done), 128'd0);

        // Asynchronous reset mid-cycle at count 2.
        send(128'h44);
        send(128'h55);
        #3 rst = 1'b1;
        #1;
        chk("arst_done", 128'(done), 128'd0);
        chk("arst_count", 128'(count), 128'd0);
        chk("arst_state_out", state_out, 128'd0);
        exp_q.delete();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        en = 1'b1; state = 128'h66;
        @(posedge clk); #1;
        en = 1'b0;
        chk("arst_resume_done", 128'(done), 128'd1);
        chk("arst_resume_data", state_out, ref_inv(128'h66));
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
